par_read_buffer: RTL and testbench

PAR_READ_BUFFER -- requirements
Module: par_read_buffer

---
 rtl/par_read_buffer.sv | 105 ++++++++++
 tb/tb_par_read_buffer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/par_read_buffer.sv
// Circular word buffer that exposes PAR_READ consecutive words per read
// and retires a variable number of them per pop.
module par_read_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int COLUMNS    = 32,
    parameter int PAR_READ   = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           wr_en,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    output logic                           full,
    input  logic                           rd_en,
    input  logic [$clog2(PAR_READ):0]      rd_stride,
    output logic [PAR_READ*DATA_WIDTH-1:0] rd_data,
    output logic                           empty,
    output logic [$clog2(COLUMNS):0]       count
);

    localparam int PW = $clog2(COLUMNS);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(PAR_READ) + 1;

    logic [DATA_WIDTH-1:0] mem [COLUMNS];

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [PW-1:0] wp_next;
    logic [PW-1:0] rp_next;
    logic [CW-1:0] fill;
    logic [CW-1:0] rp_sum;
    logic [SW-1:0] stride;
    logic          wr_ok;
    logic          rd_ok;

    // Occupancy from the pointers; a wrapped writer adds one lap.
    always_comb begin
        fill = {1'b0, wp} - {1'b0, rp};
        if (wp < rp) begin
            fill = fill + CW'(COLUMNS);
        end
    end

    assign count = fill;
    assign full  = (fill == CW'(COLUMNS - 1));
    assign empty = (fill < CW'(PAR_READ));
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    // Clamp the stride and advance both pointers with wraparound.
    always_comb begin
        stride = rd_stride;
        if (rd_stride > SW'(PAR_READ)) begin
            stride = SW'(PAR_READ);
        end
        rp_sum  = {1'b0, rp} + CW'(stride);
        rp_next = PW'(rp_sum);
        if (rp_sum >= CW'(COLUMNS)) begin
            rp_next = PW'(rp_sum - CW'(COLUMNS));
        end
        wp_next = wp + PW'(1);
        if (wp == PW'(COLUMNS - 1)) begin
            wp_next = '0;
        end
    end

    // Pointer registers; reset empties the buffer without touching memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (wr_ok) begin
                wp <= wp_next;
            end
            if (rd_ok) begin
                rp <= rp_next;
            end
        end
    end

    // Storage array, deliberately left uncleared by reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wp] <= wr_data;
        end
    end

    for (genvar i = 0; i < PAR_READ; i++) begin : g_lane
        logic [CW-1:0] lsum;
        logic [PW-1:0] idx;

        // Address of lane i: rp + i folded back into the array.
        always_comb begin
            lsum = {1'b0, rp} + CW'(i);
            idx  = PW'(lsum);
            if (lsum >= CW'(COLUMNS)) begin
                idx = PW'(lsum - CW'(COLUMNS));
            end
        end

        assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = mem[idx];
    end

endmodule

// File: tb/tb_par_read_buffer.sv
// Directed bench for par_read_buffer: stimulus queues expectations,
// a time-driven monitor pops and compares them.
module tb_par_read_buffer;

    localparam int DW = 8;
    localparam int C  = 8;
    localparam int P  = 4;

    logic          clk;
    logic          rst;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          full;
    logic          rd_en;
    logic [2:0]    rd_stride;
    logic [31:0]   rd_data;
    logic          empty;
    logic [3:0]    count;

    par_read_buffer #(
        .DATA_WIDTH(DW),
        .COLUMNS   (C),
        .PAR_READ  (P)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .rd_en    (rd_en),
        .rd_stride(rd_stride),
        .rd_data  (rd_data),
        .empty    (empty),
        .count    (count)
    );

    typedef struct {
        time         t;
        string       name;
        int          cnt;
        logic        e_empty;
        logic        e_full;
        logic        chk_data;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    int   compared;
    int   mismatched;
    logic stim_done;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expectation to be checked at absolute time t.
    task automatic expect_at(input time t, input string name,
                             input int cnt, input logic e_empty,
                             input logic e_full, input logic chk,
                             input logic [31:0] data);
        exp_t e;
        e.t        = t;
        e.name     = name;
        e.cnt      = cnt;
        e.e_empty  = e_empty;
        e.e_full   = e_full;
        e.chk_data = chk;
        e.data     = data;
        sb.push_back(e);
    endtask

    // Drive one cycle's request; expected state is visible after the edge.
    task automatic step(input logic w, input logic [7:0] wd,
                        input logic r, input logic [2:0] st,
                        input string name, input int cnt,
                        input logic e_empty, input logic e_full,
                        input logic chk, input logic [31:0] data);
        @(posedge clk);
        #1;
        wr_en     = w;
        wr_data   = wd;
        rd_en     = r;
        rd_stride = st;
        expect_at($time + 14, name, cnt, e_empty, e_full, chk, data);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        rd_en     = 1'b0;
        rd_stride = 3'd0;
    endtask

    // Monitor: compare the oldest expectation once its time arrives.
    initial begin
        exp_t e;
        forever begin
            wait (sb.size() > 0);
            e = sb[0];
            if ($time < e.t) #(e.t - $time);
            compared++;
            if (count !== 4'(e.cnt)) begin
                mismatched++;
                $display("FAIL %s count: got %0d want %0d",
                         e.name, count, e.cnt);
            end
            compared++;
            if (empty !== e.e_empty) begin
                mismatched++;
                $display("FAIL %s empty: got %b want %b",
                         e.name, empty, e.e_empty);
            end
            compared++;
            if (full !== e.e_full) begin
                mismatched++;
                $display("FAIL %s full: got %b want %b",
                         e.name, full, e.e_full);
            end
            if (e.chk_data) begin
                compared++;
                if (rd_data !== e.data) begin
                    mismatched++;
                    $display("FAIL %s rd_data: got %h want %h",
                             e.name, rd_data, e.data);
                end
            end
            void'(sb.pop_front());
        end
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        stim_done  = 1'b0;
        rst        = 1'b1;
        wr_en      = 1'b0;
        wr_data    = 8'h00;
        rd_en      = 1'b0;
        rd_stride  = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        expect_at($time + 4, "reset", 0, 1'b1, 1'b0, 1'b0, 32'h0);

        step(1, 8'h10, 0, 3'd0, "wr10", 1, 1, 0, 0, 32'h0);
        step(1, 8'h11, 0, 3'd0, "wr11", 2, 1, 0, 0, 32'h0);
        step(1, 8'h12, 0, 3'd0, "wr12", 3, 1, 0, 0, 32'h0);
        step(1, 8'h13, 0, 3'd0, "wr13", 4, 0, 0, 1, 32'h13121110);
        step(1, 8'h14, 0, 3'd0, "wr14", 5, 0, 0, 1, 32'h13121110);
        step(1, 8'h15, 0, 3'd0, "wr15", 6, 0, 0, 1, 32'h13121110);
        step(1, 8'h16, 0, 3'd0, "wr16", 7, 0, 1, 1, 32'h13121110);
        step(1, 8'hee, 0, 3'd0, "wr_full", 7, 0, 1, 1, 32'h13121110);
        step(1, 8'h17, 1, 3'd2, "full_pop2", 5, 0, 0, 1, 32'h15141312);
        step(1, 8'h27, 1, 3'd4, "pop4_wr", 2, 1, 0, 0, 32'h0);
        step(1, 8'h30, 0, 3'd0, "wr30", 3, 1, 0, 0, 32'h0);
        step(1, 8'h31, 0, 3'd0, "wr31", 4, 0, 0, 1, 32'h31302716);
        step(1, 8'h32, 0, 3'd0, "wr32", 5, 0, 0, 1, 32'h31302716);
        step(1, 8'h33, 0, 3'd0, "wr33", 6, 0, 0, 1, 32'h31302716);
        step(0, 8'h00, 1, 3'd0, "pop0", 6, 0, 0, 1, 32'h31302716);
        step(0, 8'h00, 1, 3'd4, "pop4_wrap", 2, 1, 0, 0, 32'h0);
        step(1, 8'h34, 0, 3'd0, "wr34", 3, 1, 0, 0, 32'h0);
        step(1, 8'h35, 0, 3'd0, "wr35", 4, 0, 0, 1, 32'h35343332);
        step(0, 8'h00, 1, 3'd7, "pop7_clamp", 0, 1, 0, 0, 32'h0);
        step(1, 8'h40, 0, 3'd0, "wr40", 1, 1, 0, 0, 32'h0);
        step(1, 8'h41, 0, 3'd0, "wr41", 2, 1, 0, 0, 32'h0);
        step(1, 8'h42, 0, 3'd0, "wr42", 3, 1, 0, 0, 32'h0);
        step(1, 8'h43, 0, 3'd0, "wr43", 4, 0, 0, 1, 32'h43424140);
        step(1, 8'h44, 0, 3'd0, "wr44", 5, 0, 0, 1, 32'h43424140);
        step(1, 8'h45, 0, 3'd0, "wr45", 6, 0, 0, 1, 32'h43424140);
        idle();
        @(negedge clk);
        #1;
        rst = 1'b1;
        expect_at($time + 2, "async_rst", 0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        wr_en   = 1'b1;
        wr_data = 8'h55;
        expect_at($time + 14, "rst_hold", 0, 1'b1, 1'b0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        wr_en = 1'b0;
        step(1, 8'h50, 0, 3'd0, "post_rst", 1, 1, 0, 0, 32'h0);
        idle();
        stim_done = 1'b1;
    end

    // Drain the scoreboard with a bounded wait, then report.
    initial begin
        wait (stim_done);
        for (int i = 0; i < 100 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        if (sb.size() > 0) begin
            mismatched++;
            $display("FAIL drain: %0d pending, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
